// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Big-endian lanes: addr[1]=0 is the upper halfword of the stored word.
    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

    function automatic logic [31:0] extendHalf(input logic [15:0] half, input logic isUnsigned);
        return isUnsigned ? {16'h0000, half} : {{16{half[15]}}, half};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write with per-halfword enables, asynchronous read, no reset.
// wrEn[1] writes bits [31:16], wrEn[0] writes bits [15:0].
module dmem_array #(
    parameter int  DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [1:0]    wrEn,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wrData,
    output logic [31:0]   rdData
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wrEn[1]) mem[addr][31:16] <= wrData[31:16];
        if (wrEn[0]) mem[addr][15:0]  <= wrData[15:0];
    end

    assign rdData = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store slave: one request at a time, response WAIT_CYCLES+1 cycles after acceptance.
// Response holds stable until resp_ready; no new request is taken while one is outstanding.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_half,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    state_t        state;
    logic [CW-1:0] waitCnt;

    logic          misaligned;
    logic          outOfRange;
    logic          accErr;
    logic          accept;
    logic [AW-1:0] wordIdx;
    logic [1:0]    wrEn;
    logic [31:0]   wrData;
    logic [31:0]   rdWord;
    logic [15:0]   rdHalf;
    logic [31:0]   loadData;

    assign wordIdx = req_addr[AW+1:2];

    always_comb begin
        misaligned = req_half ? req_addr[0] : (req_addr[1:0] != 2'b00);
        outOfRange = (req_addr[31:2] >= 30'(DEPTH_WORDS));
        accErr     = misaligned | outOfRange;
        accept     = (state == IDLE) && req_valid;

        // Errored stores must leave the array untouched.
        wrEn = WE_NONE;
        if (accept && req_write && !accErr) begin
            if (!req_half)                  wrEn = WE_WORD;
            else if (req_addr[1] == HALF_LO) wrEn = WE_LO;
            else                            wrEn = WE_HI;
        end
        wrData = req_half ? {2{req_wdata[15:0]}} : req_wdata;

        rdHalf   = (req_addr[1] == HALF_HI) ? rdWord[31:16] : rdWord[15:0];
        loadData = req_half ? extendHalf(rdHalf, req_unsigned) : rdWord;
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) uArray (
        .clk    (clk),
        .wrEn   (wrEn),
        .addr   (wordIdx),
        .wrData (wrData),
        .rdData (rdWord)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waitCnt    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                        waitCnt    <= CNT_LOAD;
                        resp_err   <= accErr;
                        resp_rdata <= (accErr || req_write) ? '0 : loadData;
                    end
                end
                WAIT: begin
                    if (waitCnt == '0) state <= RESP;
                    else               waitCnt <= waitCnt - CW'(1);
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_write;
    logic        req_half;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        respValid [2];
    logic [31:0] respRdata [2];
    logic        respErr   [2];

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_write(req_write), .req_half(req_half), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(respValid[0]), .resp_ready(resp_ready),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_write(req_write), .req_half(req_half), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(respValid[1]), .resp_ready(resp_ready),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1])
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkBit(input string tag, input logic obs, input logic exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int exp);
        nAssert++;
        assert (obs == exp) else begin
            nFail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the response consumed.
    task automatic doReq(input int sel, input logic wr, input logic hf, input logic un,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!reqReady[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_write     = wr;
        req_half      = hf;
        req_unsigned  = un;
        req_addr      = addr;
        req_wdata     = wdata;
        reqValid[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[sel] = 1'b0;
        // Scramble request fields: only the acceptance edge may matter.
        req_write    = ~wr;
        req_half     = ~hf;
        req_unsigned = ~un;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        lat = 1;
        while (!respValid[sel] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata      = respRdata[sel];
        err        = respErr[sel];
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic xact(input string tag, input int sel, input logic wr, input logic hf,
                        input logic un, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expData, input logic expErr);
        logic [31:0] rd;
        logic        er;
        int          lat;
        doReq(sel, wr, hf, un, addr, wdata, rd, er, lat);
        chkInt({tag, ".lat"}, lat, (sel == 0) ? 3 : 1);
        chk32({tag, ".rdata"}, rd, expData);
        chkBit({tag, ".err"}, er, expErr);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        reqValid[0]  = 1'b0;
        reqValid[1]  = 1'b0;
        req_write    = 1'b0;
        req_half     = 1'b0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b0;

        repeat (3) @(negedge clk);
        chkBit("rst.req_ready", reqReady[0], 1'b1);
        chkBit("rst.resp_valid", respValid[0], 1'b0);
        chk32("rst.resp_rdata", respRdata[0], 32'h0);
        chkBit("rst.resp_err", respErr[0], 1'b0);
        chkBit("rst.req_ready_w0", reqReady[1], 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store then load
        xact("sw10", 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact("lw10", 0, 0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Halfword extension, big-endian lanes
        xact("sw20",   0, 1, 0, 0, 32'h20, 32'h80017FFF, 32'h0, 1'b0);
        xact("lh20",   0, 0, 1, 0, 32'h20, 32'h0, 32'hFFFF8001, 1'b0);
        xact("lhu20",  0, 0, 1, 1, 32'h20, 32'h0, 32'h00008001, 1'b0);
        xact("lh22",   0, 0, 1, 0, 32'h22, 32'h0, 32'h00007FFF, 1'b0);

        // Halfword stores touch only their lane
        xact("sw20a",  0, 1, 0, 0, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0);
        xact("sh22",   0, 1, 1, 0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0);
        xact("lw20a",  0, 0, 0, 0, 32'h20, 32'h0, 32'hAAAA1234, 1'b0);
        xact("sh20",   0, 1, 1, 0, 32'h20, 32'h00005678, 32'h0, 1'b0);
        xact("lw20b",  0, 0, 0, 0, 32'h20, 32'h0, 32'h56781234, 1'b0);

        // Errors leave memory unchanged
        xact("sw04",   0, 1, 0, 0, 32'h04, 32'h5, 32'h0, 1'b0);
        xact("lw06",   0, 0, 0, 0, 32'h06, 32'h0, 32'h0, 1'b1);
        xact("sh05",   0, 1, 1, 0, 32'h05, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact("lw400",  0, 0, 0, 0, 32'h400, 32'h0, 32'h0, 1'b1);
        xact("sw404",  0, 1, 0, 0, 32'h404, 32'hBAD0BAD0, 32'h0, 1'b1);
        xact("lw04",   0, 0, 0, 0, 32'h04, 32'h0, 32'h5, 1'b0);

        // Backpressure: response held 5 cycles, a stray request is ignored
        req_write    = 1'b0;
        req_half     = 1'b0;
        req_addr     = 32'h10;
        reqValid[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        n = 0;
        while (!respValid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chkBit("bp.resp_valid", respValid[0], 1'b1);
            chk32("bp.resp_rdata", respRdata[0], 32'hDEADBEEF);
            chkBit("bp.resp_err", respErr[0], 1'b0);
            chkBit("bp.req_ready", reqReady[0], 1'b0);
            if (i == 2) begin
                req_write   = 1'b1;
                req_addr    = 32'h10;
                req_wdata   = 32'h0;
                reqValid[0] = 1'b1;
            end else begin
                reqValid[0] = 1'b0;
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chkBit("bp.done_valid", respValid[0], 1'b0);
        chkBit("bp.done_ready", reqReady[0], 1'b1);
        xact("bp.lw10", 0, 0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Reset in the middle of WAIT
        req_write   = 1'b1;
        req_half    = 1'b0;
        req_addr    = 32'h30;
        req_wdata   = 32'h77;
        reqValid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chkBit("rstw.req_ready", reqReady[0], 1'b1);
        chkBit("rstw.resp_valid", respValid[0], 1'b0);
        chk32("rstw.resp_rdata", respRdata[0], 32'h0);
        chkBit("rstw.resp_err", respErr[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chkBit("rstw.no_resp", respValid[0], 1'b0);
        end
        xact("rstw.lw30", 0, 0, 0, 0, 32'h30, 32'h0, 32'h77, 1'b0);

        // Zero wait cycles: one-cycle latency and reset while in RESP
        xact("w0.sw40", 1, 1, 0, 0, 32'h40, 32'h12345678, 32'h0, 1'b0);
        xact("w0.lhu42", 1, 0, 1, 1, 32'h42, 32'h0, 32'h00005678, 1'b0);
        req_write   = 1'b1;
        req_half    = 1'b0;
        req_addr    = 32'h30;
        req_wdata   = 32'h99;
        reqValid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid[1] = 1'b0;
        chkBit("rst0.resp_valid_pre", respValid[1], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkBit("rst0.resp_valid", respValid[1], 1'b0);
        chkBit("rst0.req_ready", reqReady[1], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chkBit("rst0.no_resp", respValid[1], 1'b0);
        end
        xact("rst0.lw30", 1, 0, 0, 0, 32'h30, 32'h0, 32'h99, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
